// File: rtl/imm_encoder.sv
// imm_encoder
// -----------
// Turns decoded RV32I instruction fields into 32-bit instruction words for the
// boot sequencer / debug-patch path feeding instruction memory. It is the
// inverse of the core's immediate decode. It also expands the `li rd, imm32`
// pseudo-instruction into either ADDI, or LUI (+ ADDI), over consecutive beats.
//
// Ports:
//   clk, rst            : clock, asynchronous active-high reset
//   in_valid / in_ready : request handshake (ready only while IDLE)
//   in_fmt              : 0=R 1=I 2=S 3=B 4=U 5=J 6=CSR 7=LI
//   in_opcode           : opcode (ignored for LI)
//   in_funct3/in_funct7 : funct fields (funct7 also carries shift funct7 and the CSR address high bits)
//   in_rd/in_rs1/in_rs2 : register indices (rs2 carries the CSR address low bits)
//   in_imm              : 32-bit immediate
//   out_valid/out_ready : output word handshake
//   out_inst            : encoded instruction word
//   out_last            : final word of the current request
//   err                 : one-cycle pulse when a request is consumed but rejected

module imm_encoder (
  input  logic        clk,
  input  logic        rst,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [2:0]  in_fmt,
  input  logic [6:0]  in_opcode,
  input  logic [2:0]  in_funct3,
  input  logic [6:0]  in_funct7,
  input  logic [4:0]  in_rd,
  input  logic [4:0]  in_rs1,
  input  logic [4:0]  in_rs2,
  input  logic [31:0] in_imm,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] out_inst,
  output logic        out_last,
  output logic        err
);

  localparam logic [2:0] FMT_R   = 3'd0;
  localparam logic [2:0] FMT_I   = 3'd1;
  localparam logic [2:0] FMT_S   = 3'd2;
  localparam logic [2:0] FMT_B   = 3'd3;
  localparam logic [2:0] FMT_U   = 3'd4;
  localparam logic [2:0] FMT_J   = 3'd5;
  localparam logic [2:0] FMT_CSR = 3'd6;
  localparam logic [2:0] FMT_LI  = 3'd7;

  localparam logic [6:0] OP_IMM = 7'h13;
  localparam logic [6:0] OP_LUI = 7'h37;

  typedef enum logic [1:0] {
    IDLE,
    OUT1,
    OUT2
  } state_e;

  state_e      state_q, state_d;
  logic [31:0] out_inst_q, out_inst_d;
  logic [31:0] second_q, second_d;
  logic        has_second_q, has_second_d;
  logic        out_last_q, out_last_d;
  logic        err_q, err_d;

  logic [31:0] enc_word1;
  logic [31:0] enc_word2;
  logic        enc_err;
  logic        enc_two;
  logic        is_shift;
  logic        fits_s12;
  logic        fits_u5;
  logic [11:0] li_lo;
  logic [19:0] li_hi;

  // Encoder: builds the word(s) for the request currently on the input bus and
  // decides whether its immediate is representable. The result is only used in
  // the cycle the request is accepted, so nothing here needs to be held.
  always_comb begin
    enc_word1 = '0;
    enc_word2 = '0;
    enc_err   = 1'b0;
    enc_two   = 1'b0;

    // Shift-immediates are OP-IMM with funct3 001 (slli) or 101 (srli/srai).
    is_shift = (in_opcode == OP_IMM) && (in_funct3[1:0] == 2'b01);
    // Signed 12-bit fit: bits 31..11 are all copies of the sign.
    fits_s12 = (in_imm[31:11] == '0) || (in_imm[31:11] == '1);
    fits_u5  = (in_imm[31:5] == '0);

    // Adding 0x800 before taking the upper 20 bits compensates for ADDI
    // sign-extending lo; the carry into bit 12 is exactly imm[11].
    li_lo = in_imm[11:0];
    li_hi = in_imm[31:12] + {19'd0, in_imm[11]};

    case (in_fmt)
      FMT_R: begin
        enc_word1 = {in_funct7, in_rs2, in_rs1, in_funct3, in_rd, in_opcode};
      end
      FMT_I: begin
        if (is_shift) begin
          enc_word1 = {in_funct7, in_imm[4:0], in_rs1, in_funct3, in_rd, in_opcode};
          enc_err   = !fits_u5;
        end else begin
          enc_word1 = {in_imm[11:0], in_rs1, in_funct3, in_rd, in_opcode};
          enc_err   = !fits_s12;
        end
      end
      FMT_S: begin
        enc_word1 = {in_imm[11:5], in_rs2, in_rs1, in_funct3, in_imm[4:0], in_opcode};
        enc_err   = !fits_s12;
      end
      FMT_B: begin
        enc_word1 = {in_imm[12], in_imm[10:5], in_rs2, in_rs1, in_funct3,
                     in_imm[4:1], in_imm[11], in_opcode};
        enc_err   = !((in_imm[31:12] == '0) || (in_imm[31:12] == '1)) || in_imm[0];
      end
      FMT_U: begin
        enc_word1 = {in_imm[31:12], in_rd, in_opcode};
        enc_err   = (in_imm[11:0] != '0);
      end
      FMT_J: begin
        enc_word1 = {in_imm[20], in_imm[10:1], in_imm[11], in_imm[19:12], in_rd, in_opcode};
        enc_err   = !((in_imm[31:20] == '0) || (in_imm[31:20] == '1)) || in_imm[0];
      end
      FMT_CSR: begin
        // CSR address arrives split as {funct7, rs2}, i.e. it lands in [31:20].
        enc_word1 = {in_funct7, in_rs2, in_imm[4:0], in_funct3, in_rd, in_opcode};
        enc_err   = !fits_u5;
      end
      FMT_LI: begin
        if (fits_s12) begin
          enc_word1 = {li_lo, 5'd0, 3'b000, in_rd, OP_IMM};
        end else begin
          enc_word1 = {li_hi, in_rd, OP_LUI};
          enc_word2 = {li_lo, in_rd, 3'b000, in_rd, OP_IMM};
          enc_two   = (li_lo != '0);
        end
      end
      default: begin
        enc_word1 = '0;
      end
    endcase
  end

  // State register: every flop of the block. Reset drops any pending word
  // immediately, which also pulls out_valid low without waiting for a clock.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= IDLE;
      out_inst_q   <= '0;
      second_q     <= '0;
      has_second_q <= 1'b0;
      out_last_q   <= 1'b0;
      err_q        <= 1'b0;
    end else begin
      state_q      <= state_d;
      out_inst_q   <= out_inst_d;
      second_q     <= second_d;
      has_second_q <= has_second_d;
      out_last_q   <= out_last_d;
      err_q        <= err_d;
    end
  end

  // Next-state logic: accept in IDLE, then walk through one or two output
  // beats. The output word only changes on a handshake, so it stays stable
  // under backpressure.
  always_comb begin
    state_d      = state_q;
    out_inst_d   = out_inst_q;
    second_d     = second_q;
    has_second_d = has_second_q;
    out_last_d   = out_last_q;
    err_d        = 1'b0;

    case (state_q)
      IDLE: begin
        if (in_valid) begin
          if (enc_err) begin
            err_d = 1'b1;
          end else begin
            state_d      = OUT1;
            out_inst_d   = enc_word1;
            out_last_d   = !enc_two;
            second_d     = enc_word2;
            has_second_d = enc_two;
          end
        end
      end
      OUT1: begin
        if (out_ready) begin
          if (has_second_q) begin
            state_d    = OUT2;
            out_inst_d = second_q;
            out_last_d = 1'b1;
          end else begin
            state_d = IDLE;
          end
        end
      end
      OUT2: begin
        if (out_ready) begin
          state_d = IDLE;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // Output logic: handshake flags come straight from the state, data from the
  // output register.
  always_comb begin
    in_ready  = (state_q == IDLE);
    out_valid = (state_q != IDLE);
    out_inst  = out_inst_q;
    out_last  = out_last_q;
    err       = err_q;
  end

endmodule
